enc8to3_serial: RTL and testbench

ENC8TO3_SERIAL -- requirements
Module: enc8to3_serial

---
 rtl/enc8to3_serial.sv | 156 +++++++++++++++
 tb/tb_enc8to3_serial.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/enc8to3_serial.sv
// rtl/enc8to3_serial.sv - serializing 8-to-3 priority encoder with valid/ack handshake
//
// Purpose:
//   Accepts an 8-bit request vector in IDLE. In EMIT it presents one 3-bit code
//   per set bit, lowest request index first, and waits for the consumer's Ack on
//   each code. After the last code is accepted, Done pulses for one cycle and
//   the block returns to IDLE.
//
// Optional feature (macro ENC_ONEHOT_CHECK_EN):
//   defined   - a vector with more than one bit set is rejected in IDLE and Err
//               pulses for one cycle.
//   undefined - multi-bit vectors are serialized and Err is tied low.
//
// Ports:
//   Clock   in   system clock, rising edge
//   Resetn  in   asynchronous active-low reset
//   D       in   [0:7] request vector, D[i] encodes to code 7-i
//   Load    in   request strobe, sampled only while Ready=1
//   Ready   out  idle, Load will be taken
//   W       out  [2:0] registered code of the current pending bit, 0 when idle
//   Valid   out  W holds a code awaiting Ack
//   Ack     in   consumer accepts W on an edge where Valid=1
//   Done    out  one-cycle pulse after the last code of a vector is accepted
//   Err     out  one-cycle pulse on a rejected vector
module enc8to3_serial (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic [0:7] D,
   input  logic       Load,
   output logic       Ready,
   output logic [2:0] W,
   output logic       Valid,
   input  logic       Ack,
   output logic       Done,
   output logic       Err
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pend_q, pend_d;
   logic [2:0] w_q, w_d;
   logic       done_q, done_d;

   // Repacking [0:7] into [7:0] places D[i] at bit 7-i, so the numeric bit
   // position of each request equals its code. Priority (lowest D index first)
   // then becomes "highest numeric bit first".
   logic [7:0] d_num;
   assign d_num = D;

   function automatic logic [2:0] top_code(input logic [7:0] v);
      logic [2:0] c;
      c = 3'd0;
      for (int b = 0; b < 8; b++) begin
         if (v[b]) c = 3'(b);
      end
      return c;
   endfunction

   logic [2:0] cur_code;
   logic [7:0] pend_rest;
   logic       d_multi;
   logic       load_ok;

   assign cur_code  = top_code(pend_q);
   assign pend_rest = pend_q & ~(8'd1 << cur_code);
   // Nonzero exactly when two or more bits are set.
   assign d_multi   = (d_num & (d_num - 8'd1)) != 8'd0;

`ifdef ENC_ONEHOT_CHECK_EN
   logic err_q, err_d;
   assign load_ok = !d_multi;
`else
   assign load_ok = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      w_d     = w_q;
      done_d  = 1'b0;
`ifdef ENC_ONEHOT_CHECK_EN
      err_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (Load && (d_num != 8'd0)) begin
               if (load_ok) begin
                  pend_d  = d_num;
                  w_d     = top_code(d_num);
                  state_d = EMIT;
               end else begin
`ifdef ENC_ONEHOT_CHECK_EN
                  err_d = 1'b1;
`endif
               end
            end
         end
         EMIT: begin
            // Load is deliberately not looked at here: a busy block ignores it.
            if (Ack) begin
               if (pend_rest == 8'd0) begin
                  pend_d  = 8'd0;
                  w_d     = 3'd0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  pend_d = pend_rest;
                  w_d    = top_code(pend_rest);
               end
            end
         end
         default: begin
            state_d = IDLE;
            pend_d  = 8'd0;
            w_d     = 3'd0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         pend_q  <= 8'd0;
         w_q     <= 3'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         w_q     <= w_d;
         done_q  <= done_d;
      end
   end

`ifdef ENC_ONEHOT_CHECK_EN
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign Err = err_q;
`else
   assign Err = 1'b0;
`endif

   assign Ready = (state_q == IDLE);
   assign Valid = (state_q == EMIT);
   assign W     = w_q;
   assign Done  = done_q;

endmodule

// File: tb/tb_enc8to3_serial.sv
// tb/tb_enc8to3_serial.sv - directed scoreboard bench for enc8to3_serial
module tb_enc8to3_serial;

   logic       Clock;
   logic       Resetn;
   logic [0:7] D;
   logic       Load;
   logic       Ready;
   logic [2:0] W;
   logic       Valid;
   logic       Ack;
   logic       Done;
   logic       Err;

   int errors = 0;
   int checks = 0;
   logic [2:0] exp_q[$];

   enc8to3_serial dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .D      (D),
      .Load   (Load),
      .Ready  (Ready),
      .W      (W),
      .Valid  (Valid),
      .Ack    (Ack),
      .Done   (Done),
      .Err    (Err)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, 8'(Ready), 8'd1);
      chk({tag, "_valid"}, 8'(Valid), 8'd0);
      chk({tag, "_w"},     8'(W),     8'd0);
   endtask

   // Scoreboard: expected codes in emission order, D[0] (code 7) first.
   task automatic push_codes(input logic [0:7] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) exp_q.push_back(3'(7 - i));
      end
   endtask

   task automatic load_vec(input logic [0:7] v);
      D    = v;
      Load = 1'b1;
      tick();
      Load = 1'b0;
   endtask

   // Consume every queued code; rnd=1 randomizes Ack to exercise stalls.
   task automatic drain(input string tag, input bit rnd);
      int guard;
      logic [2:0] popped;
      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
         Ack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         chk({tag, "_valid"}, 8'(Valid), 8'd1);
         chk({tag, "_ready"}, 8'(Ready), 8'd0);
         chk({tag, "_w"},     8'(W),     8'(exp_q[0]));
         tick();
         if (Ack) popped = exp_q.pop_front();
         guard++;
      end
      chk({tag, "_drained"}, 8'(exp_q.size()), 8'd0);
      chk({tag, "_done"}, 8'(Done), 8'd1);
      chk_idle({tag, "_end"});
      Ack = 1'b0;
      tick();
      chk({tag, "_done_once"}, 8'(Done), 8'd0);
   endtask

   initial begin
      Resetn = 1'b1;
      D      = 8'd0;
      Load   = 1'b0;
      Ack    = 1'b0;

      // Reset asserted before any clock edge must take effect immediately.
      #1 Resetn = 1'b0;
      #1;
      chk_idle("rst");
      chk("rst_done", 8'(Done), 8'd0);
      chk("rst_err",  8'(Err),  8'd0);
      tick();
      tick();
      Resetn = 1'b1;
      tick();
      chk_idle("post_rst");

      // Single request D[2] with Ack already high.
      Ack = 1'b1;
      push_codes(8'b00100000);
      load_vec(8'b00100000);
      chk("d2_code", 8'(W), 8'h5);
      drain("d2", 1'b0);

      // Load with an empty vector is ignored.
      D    = 8'd0;
      Load = 1'b1;
      tick();
      Load = 1'b0;
      chk_idle("zero");
      chk("zero_done", 8'(Done), 8'd0);
      chk("zero_err",  8'(Err),  8'd0);

`ifdef ENC_ONEHOT_CHECK_EN
      load_vec(8'b10000001);
      chk("multi_err", 8'(Err), 8'd1);
      chk_idle("multi_rej");
      tick();
      chk("multi_err_once", 8'(Err), 8'd0);
      chk_idle("multi_rej2");
      Ack = 1'b1;
      push_codes(8'b00010000);
      load_vec(8'b00010000);
      chk("d3_code", 8'(W), 8'h4);
      drain("d3", 1'b0);
`else
      Ack = 1'b1;
      push_codes(8'b10000001);
      load_vec(8'b10000001);
      chk("multi_err", 8'(Err), 8'd0);
      drain("multi", 1'b0);

      push_codes(8'b01011010);
      load_vec(8'b01011010);
      drain("multi_rnd", 1'b1);
`endif

      // Stall: Ack low for five cycles while Load pulses with another vector.
      Ack = 1'b0;
      push_codes(8'b00000010);
      load_vec(8'b00000010);
      D    = 8'b10000000;
      Load = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 8'(Valid), 8'd1);
         chk("stall_w",     8'(W),     8'h1);
         chk("stall_done",  8'(Done),  8'd0);
         tick();
      end
      Load = 1'b0;
      drain("stall", 1'b0);

      // Reset in the middle of a vector discards the rest with no Done.
`ifndef ENC_ONEHOT_CHECK_EN
      Ack = 1'b1;
      load_vec(8'b11000000);
      chk("abort_w0", 8'(W), 8'h7);
      tick();
      chk("abort_w1", 8'(W), 8'h6);
      chk("abort_v1", 8'(Valid), 8'd1);
      #2 Resetn = 1'b0;
      #1;
      chk_idle("abort_rst");
      chk("abort_done", 8'(Done), 8'd0);
      tick();
      Resetn = 1'b1;
      Ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle("abort_after");
         chk("abort_no_done", 8'(Done), 8'd0);
      end
`endif

      // Ack while idle does nothing.
      Ack = 1'b1;
      tick();
      chk_idle("idle_ack");
      chk("idle_ack_done", 8'(Done), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
